// File: rtl/inst_mem_responder.sv
// inst_mem_responder
// Memory-side responder for the core instruction fetch port. Accepts fetch
// requests, reads 64-bit aligned words from the instruction memory port (one
// access outstanding at most) and returns them in order through a response
// FIFO that honours the core's busy backpressure.
//
// Optional feature macro: MIST1032ISA_INST_RESP_PAGEFAULT_EN
//   defined   : requests with a non-zero MMU mode at or above P_PAGE_LIMIT are
//               answered directly with a page-fault response (no memory access)
//   undefined : no fault check, every request goes to memory, fault bit is 0

module inst_mem_responder #(
    parameter int unsigned P_DEPTH      = 4,
    parameter logic [31:0] P_PAGE_LIMIT = 32'h0010_0000
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iINST_REQ,
    output logic        oINST_LOCK,
    input  logic [1:0]  iINST_MMUMOD,
    input  logic [31:0] iINST_PDT,
    input  logic [31:0] iINST_ADDR,
    output logic        oINST_VALID,
    input  logic        iINST_BUSY,
    output logic        oINST_PAGEFAULT,
    output logic        oINST_QUEUE_FLUSH,
    output logic [63:0] oINST_DATA,
    output logic [27:0] oINST_MMU_FLAGS,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic [63:0] iMEM_DATA
);

    localparam int unsigned LP_AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int unsigned LP_CW = LP_AW + 1;

    localparam logic [1:0] L_IDLE     = 2'd0;
    localparam logic [1:0] L_MEM_REQ  = 2'd1;
    localparam logic [1:0] L_MEM_WAIT = 2'd2;
    localparam logic [1:0] L_DISCARD  = 2'd3;

    // Flag word returned to the core alongside each response
    function automatic logic [27:0] f_inst_flags(input logic fault, input logic [1:0] mmumod);
        return {24'h00_0000, 1'b0, fault, mmumod};
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [28:0]      addr_q, addr_d;
    logic [1:0]       mmumod_q, mmumod_d;
    logic             flush_q;

    logic [63:0]      data_mem_q   [P_DEPTH];
    logic             fault_mem_q  [P_DEPTH];
    logic [1:0]       mmumod_mem_q [P_DEPTH];
    logic [LP_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LP_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LP_CW-1:0] count_q, count_d;

    logic             empty_s;
    logic             full_s;
    logic             lock_s;
    logic             accept_s;
    logic             fault_s;
    logic             fault_push_s;
    logic             mem_push_s;
    logic             push_s;
    logic             pop_s;
    logic [63:0]      push_data_s;
    logic [1:0]       push_mmumod_s;
    logic             unused_s;

    // ------------------------------------------------------------------
    // Request acceptance and fault decision
    // ------------------------------------------------------------------
    assign empty_s  = (count_q == {LP_CW{1'b0}});
    assign full_s   = (count_q == LP_CW'(P_DEPTH));
    assign lock_s   = (state_q != L_IDLE) | full_s;
    assign accept_s = iINST_REQ & ~lock_s & ~iFLUSH;

`ifdef MIST1032ISA_INST_RESP_PAGEFAULT_EN
    assign fault_s  = (iINST_MMUMOD != 2'b00) && (iINST_ADDR >= P_PAGE_LIMIT);
    assign unused_s = ^{iINST_PDT};
`else
    assign fault_s  = 1'b0;
    assign unused_s = ^{iINST_PDT, P_PAGE_LIMIT, iINST_ADDR[2:0]};
`endif

    // A fault is answered straight from IDLE; a memory word is pushed only
    // while the access is live (flush turns it into a discarded access).
    assign fault_push_s  = accept_s & fault_s;
    assign mem_push_s    = (state_q == L_MEM_WAIT) & iMEM_VALID & ~iFLUSH;
    assign push_s        = fault_push_s | mem_push_s;
    assign pop_s         = ~empty_s & ~iINST_BUSY & ~iFLUSH;
    assign push_data_s   = fault_push_s ? 64'h0 : iMEM_DATA;
    assign push_mmumod_s = fault_push_s ? iINST_MMUMOD : mmumod_q;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    // Next-state logic; flush wins over every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE: begin
                if (accept_s && !fault_s) begin
                    state_d = L_MEM_REQ;
                end else begin
                    state_d = L_IDLE;
                end
            end
            L_MEM_REQ: begin
                if (iFLUSH) begin
                    state_d = L_IDLE;
                end else if (!iMEM_LOCK) begin
                    state_d = L_MEM_WAIT;
                end else begin
                    state_d = L_MEM_REQ;
                end
            end
            L_MEM_WAIT: begin
                // If the data returns in the flush cycle itself it is already
                // dropped, so there is nothing left to wait for in DISCARD.
                if (iFLUSH) begin
                    state_d = iMEM_VALID ? L_IDLE : L_DISCARD;
                end else if (iMEM_VALID) begin
                    state_d = L_IDLE;
                end else begin
                    state_d = L_MEM_WAIT;
                end
            end
            L_DISCARD: begin
                if (iMEM_VALID) begin
                    state_d = L_IDLE;
                end else begin
                    state_d = L_DISCARD;
                end
            end
            default: begin
                state_d = L_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= L_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold the captured request unless a new one is accepted
    always_comb begin
        if (accept_s) begin
            addr_d   = iINST_ADDR[31:3];
            mmumod_d = iINST_MMUMOD;
        end else begin
            addr_d   = addr_q;
            mmumod_d = mmumod_q;
        end
    end

    // Captured request registers and the one-cycle flush notification
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            addr_q   <= 29'h0;
            mmumod_q <= 2'b00;
            flush_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            mmumod_q <= mmumod_d;
            flush_q  <= iFLUSH;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    // Pointer and occupancy update; flush empties the queue outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFLUSH) begin
            wr_ptr_d = {LP_AW{1'b0}};
            rd_ptr_d = {LP_AW{1'b0}};
            count_d  = {LP_CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + LP_AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + LP_AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + LP_CW'(1);
                2'b01:   count_d = count_q - LP_CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO pointers, occupancy and entry storage
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr_q <= {LP_AW{1'b0}};
            rd_ptr_q <= {LP_AW{1'b0}};
            count_q  <= {LP_CW{1'b0}};
            for (int i = 0; i < int'(P_DEPTH); i++) begin
                data_mem_q[i]   <= 64'h0;
                fault_mem_q[i]  <= 1'b0;
                mmumod_mem_q[i] <= 2'b00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                data_mem_q[wr_ptr_q]   <= push_data_s;
                fault_mem_q[wr_ptr_q]  <= fault_push_s;
                mmumod_mem_q[wr_ptr_q] <= push_mmumod_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The head entry is only presented while the queue holds something, so
    // the data/flag outputs read zero whenever no response is offered.
    assign oINST_LOCK        = lock_s;
    assign oINST_VALID       = ~empty_s;
    assign oINST_DATA        = empty_s ? 64'h0 : data_mem_q[rd_ptr_q];
    assign oINST_PAGEFAULT   = empty_s ? 1'b0  : fault_mem_q[rd_ptr_q];
    assign oINST_MMU_FLAGS   = empty_s ? 28'h0 :
                               f_inst_flags(fault_mem_q[rd_ptr_q], mmumod_mem_q[rd_ptr_q]);
    assign oINST_QUEUE_FLUSH = flush_q;
    assign oMEM_REQ          = (state_q == L_MEM_REQ);
    assign oMEM_ADDR         = {addr_q, 3'b000};

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: stimulus pushes the expected
// response, a negedge monitor pops and compares whenever the core side
// takes a response. Works in both builds of the page-fault option.

module tb_inst_mem_responder;

    typedef struct {
        logic        pf;
        logic [63:0] data;
        logic [27:0] flags;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iFLUSH = 1'b0;
    logic        iINST_REQ = 1'b0;
    logic        oINST_LOCK;
    logic [1:0]  iINST_MMUMOD = 2'b00;
    logic [31:0] iINST_PDT = 32'h0;
    logic [31:0] iINST_ADDR = 32'h0;
    logic        oINST_VALID;
    logic        iINST_BUSY = 1'b0;
    logic        oINST_PAGEFAULT;
    logic        oINST_QUEUE_FLUSH;
    logic [63:0] oINST_DATA;
    logic [27:0] oINST_MMU_FLAGS;
    logic        oMEM_REQ;
    logic        iMEM_LOCK = 1'b0;
    logic [31:0] oMEM_ADDR;
    logic        iMEM_VALID = 1'b0;
    logic [63:0] iMEM_DATA = 64'h0;

    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];

    inst_mem_responder #(.P_DEPTH(4), .P_PAGE_LIMIT(32'h0010_0000)) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(iFLUSH), .iINST_REQ(iINST_REQ),
        .oINST_LOCK(oINST_LOCK), .iINST_MMUMOD(iINST_MMUMOD), .iINST_PDT(iINST_PDT),
        .iINST_ADDR(iINST_ADDR), .oINST_VALID(oINST_VALID), .iINST_BUSY(iINST_BUSY),
        .oINST_PAGEFAULT(oINST_PAGEFAULT), .oINST_QUEUE_FLUSH(oINST_QUEUE_FLUSH),
        .oINST_DATA(oINST_DATA), .oINST_MMU_FLAGS(oINST_MMU_FLAGS), .oMEM_REQ(oMEM_REQ),
        .iMEM_LOCK(iMEM_LOCK), .oMEM_ADDR(oMEM_ADDR), .iMEM_VALID(iMEM_VALID),
        .iMEM_DATA(iMEM_DATA)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic pf, input logic [63:0] data, input logic [27:0] flags);
        rsp_t r;
        r.pf = pf; r.data = data; r.flags = flags;
        exp_q.push_back(r);
    endtask

    // Issue one request that goes to memory, return data after lat wait cycles
    task automatic do_fetch(input logic [31:0] addr, input logic [1:0] mmu,
                            input logic [63:0] data, input int lat,
                            input logic [31:0] exp_maddr, input logic [27:0] exp_flags);
        check("accept_lock", oINST_LOCK, 1'b0);
        iINST_REQ = 1'b1; iINST_ADDR = addr; iINST_MMUMOD = mmu;
        tick();
        iINST_REQ = 1'b0;
        check("mem_req", oMEM_REQ, 1'b1);
        check("mem_addr", oMEM_ADDR, exp_maddr);
        tick();
        check("mem_req_drop", oMEM_REQ, 1'b0);
        repeat (lat) tick();
        iMEM_VALID = 1'b1; iMEM_DATA = data;
        push_exp(1'b0, data, exp_flags);
        tick();
        iMEM_VALID = 1'b0;
    endtask

    // Monitor: compare on every pop, and check the head is held while busy
    initial begin
        rsp_t r;
        logic hold;
        logic [63:0] h_data;
        logic [27:0] h_flags;
        logic        h_pf;
        hold = 1'b0; h_data = 64'h0; h_flags = 28'h0; h_pf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || iFLUSH) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("stable_valid", oINST_VALID, 1'b1);
                    check("stable_data", oINST_DATA, h_data);
                    check("stable_flags", oINST_MMU_FLAGS, h_flags);
                    check("stable_pf", oINST_PAGEFAULT, h_pf);
                end
                hold = 1'b0;
                if (oINST_VALID && !iINST_BUSY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", oINST_DATA, 64'hxxxx_xxxx_xxxx_xxxx);
                    end else begin
                        r = exp_q.pop_front();
                        check("rsp_pf", oINST_PAGEFAULT, r.pf);
                        check("rsp_data", oINST_DATA, r.data);
                        check("rsp_flags", oINST_MMU_FLAGS, r.flags);
                    end
                end else if (oINST_VALID) begin
                    hold = 1'b1; h_data = oINST_DATA; h_flags = oINST_MMU_FLAGS;
                    h_pf = oINST_PAGEFAULT;
                end
            end
        end
    end

    initial begin
        logic [1:0] fmmu [4];
        logic [27:0] fflg [4];
        fmmu[0] = 2'b01; fmmu[1] = 2'b10; fmmu[2] = 2'b11; fmmu[3] = 2'b01;
        fflg[0] = 28'h5; fflg[1] = 28'h6; fflg[2] = 28'h7; fflg[3] = 28'h5;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", oINST_VALID, 1'b0);
        check("rst_mem_req", oMEM_REQ, 1'b0);
        check("rst_qflush", oINST_QUEUE_FLUSH, 1'b0);
        check("rst_pf", oINST_PAGEFAULT, 1'b0);
        check("rst_data", oINST_DATA, 64'h0);
        check("rst_flags", oINST_MMU_FLAGS, 28'h0);
        check("rst_maddr", oMEM_ADDR, 32'h0);
        check("rst_lock", oINST_LOCK, 1'b0);
        tick();

        // Basic fetch, response one cycle after return
        do_fetch(32'h0000_1004, 2'b00, 64'hDEAD_BEEF_0123_4567, 2, 32'h0000_1000, 28'h0);
        check("basic_valid", oINST_VALID, 1'b1);
        tick();
        check("basic_empty", oINST_VALID, 1'b0);

        // Translation on but just below the limit: normal memory access
        do_fetch(32'h000F_FFFF, 2'b10, 64'h1111_2222_3333_4444, 0, 32'h000F_FFF8, 28'h2);
        tick();

`ifdef MIST1032ISA_INST_RESP_PAGEFAULT_EN
        // Fault: no memory access, fault response next cycle
        check("flt_lock", oINST_LOCK, 1'b0);
        iINST_REQ = 1'b1; iINST_ADDR = 32'h0020_0000; iINST_MMUMOD = 2'b01;
        push_exp(1'b1, 64'h0, 28'h5);
        tick();
        iINST_REQ = 1'b0;
        check("flt_no_memreq", oMEM_REQ, 1'b0);
        check("flt_valid", oINST_VALID, 1'b1);
        check("flt_pf", oINST_PAGEFAULT, 1'b1);
        check("flt_lock_after", oINST_LOCK, 1'b0);
        tick();

        // Backpressure: four faults back to back fill the FIFO
        iINST_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_lock_free", oINST_LOCK, 1'b0);
            iINST_REQ = 1'b1; iINST_ADDR = 32'h0010_0000 + 32'(i * 8); iINST_MMUMOD = fmmu[i];
            push_exp(1'b1, 64'h0, fflg[i]);
            tick();
        end
        iINST_REQ = 1'b0;
        check("bp_no_memreq", oMEM_REQ, 1'b0);
`else
        // Without the fault check the same request goes to memory
        do_fetch(32'h0020_0000, 2'b01, 64'h0BAD_F00D_0000_0001, 1, 32'h0020_0000, 28'h1);
        tick();

        // Backpressure: four fetches fill the FIFO
        iINST_BUSY = 1'b1;
        do_fetch(32'h0000_0100, 2'b00, 64'hA000_0000_0000_000A, 0, 32'h0000_0100, 28'h0);
        do_fetch(32'h0000_010F, 2'b01, 64'hB000_0000_0000_000B, 1, 32'h0000_0108, 28'h1);
        do_fetch(32'h0000_0110, 2'b10, 64'hC000_0000_0000_000C, 0, 32'h0000_0110, 28'h2);
        do_fetch(32'h0000_011C, 2'b11, 64'hD000_0000_0000_000D, 2, 32'h0000_0118, 28'h3);
`endif
        check("bp_full_lock", oINST_LOCK, 1'b1);
        repeat (3) tick();
        check("bp_still_lock", oINST_LOCK, 1'b1);
        iINST_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_valid", oINST_VALID, 1'b1);
            tick();
        end
        check("bp_drained", oINST_VALID, 1'b0);
        check("bp_unlock", oINST_LOCK, 1'b0);

        // Memory lock held five cycles in MEM_REQ
        iMEM_LOCK = 1'b1;
        iINST_REQ = 1'b1; iINST_ADDR = 32'h0000_4A3E; iINST_MMUMOD = 2'b00;
        tick();
        iINST_REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("mlock_req", oMEM_REQ, 1'b1);
            check("mlock_addr", oMEM_ADDR, 32'h0000_4A38);
            check("mlock_lock", oINST_LOCK, 1'b1);
            tick();
        end
        iMEM_LOCK = 1'b0;
        tick();
        check("mlock_wait", oMEM_REQ, 1'b0);
        iMEM_VALID = 1'b1; iMEM_DATA = 64'h5555_6666_7777_8888;
        push_exp(1'b0, 64'h5555_6666_7777_8888, 28'h0);
        tick();
        iMEM_VALID = 1'b0;
        check("mlock_valid", oINST_VALID, 1'b1);
        tick();

        // Flush while in MEM_WAIT with two entries queued
        iINST_BUSY = 1'b1;
        do_fetch(32'h0000_0200, 2'b00, 64'h0000_0000_0000_0201, 0, 32'h0000_0200, 28'h0);
        do_fetch(32'h0000_0208, 2'b00, 64'h0000_0000_0000_0209, 0, 32'h0000_0208, 28'h0);
        iINST_REQ = 1'b1; iINST_ADDR = 32'h0000_0210; iINST_MMUMOD = 2'b00;
        tick();
        iINST_REQ = 1'b0;
        tick();
        iFLUSH = 1'b1;
        exp_q.delete();
        tick();
        iFLUSH = 1'b0;
        check("fl_qflush", oINST_QUEUE_FLUSH, 1'b1);
        check("fl_empty", oINST_VALID, 1'b0);
        check("fl_discard_lock", oINST_LOCK, 1'b1);
        tick();
        check("fl_qflush_pulse", oINST_QUEUE_FLUSH, 1'b0);
        iMEM_VALID = 1'b1; iMEM_DATA = 64'hFFFF_0000_FFFF_0000;
        tick();
        iMEM_VALID = 1'b0;
        check("fl_dropped", oINST_VALID, 1'b0);
        check("fl_idle", oINST_LOCK, 1'b0);
        iINST_BUSY = 1'b0;
        do_fetch(32'h0000_0300, 2'b00, 64'h0123_4567_89AB_CDEF, 1, 32'h0000_0300, 28'h0);
        check("fl_new_valid", oINST_VALID, 1'b1);
        tick();

        // Reset in MEM_WAIT, then a stray memory return
        iINST_BUSY = 1'b1;
        do_fetch(32'h0000_0400, 2'b11, 64'h4444_0000_0000_4444, 0, 32'h0000_0400, 28'h3);
        iINST_REQ = 1'b1; iINST_ADDR = 32'h0000_0408; iINST_MMUMOD = 2'b00;
        tick();
        iINST_REQ = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        iINST_BUSY = 1'b0;
        check("mrst_valid", oINST_VALID, 1'b0);
        check("mrst_mem_req", oMEM_REQ, 1'b0);
        check("mrst_pf", oINST_PAGEFAULT, 1'b0);
        check("mrst_data", oINST_DATA, 64'h0);
        check("mrst_flags", oINST_MMU_FLAGS, 28'h0);
        check("mrst_maddr", oMEM_ADDR, 32'h0);
        check("mrst_lock", oINST_LOCK, 1'b0);
        iMEM_VALID = 1'b1; iMEM_DATA = 64'h9999_9999_9999_9999;
        tick();
        iMEM_VALID = 1'b0;
        check("stray_ignored", oINST_VALID, 1'b0);
        tick();
        check("stray_still_empty", oINST_VALID, 1'b0);

        // Every expected response must have been delivered
        repeat (4) tick();
        check("exp_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
